// File: rtl/byte_unstriping_rx.sv
// Receive-side lane unstriper: per-lane FIFOs absorb inter-lane skew and a round-robin
// reader rebuilds the serial byte stream through a registered, backpressured output stage.
module byte_unstriping_rx #(
    parameter int unsigned LANES = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [W*LANES-1:0] lane_data,
    input  logic [LANES-1:0]   lane_valid,
    input  logic               out_ready,
    output logic [W-1:0]       data_out,
    output logic               valid_out,
    output logic [LANES-1:0]   lane_full,
    output logic               overflow
);
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]     mem_q [LANES][DEPTH];
    logic [AW-1:0]    wr_q  [LANES];
    logic [AW-1:0]    wr_d  [LANES];
    logic [AW-1:0]    rd_q  [LANES];
    logic [AW-1:0]    rd_d  [LANES];
    logic [CW-1:0]    cnt_q [LANES];
    logic [CW-1:0]    cnt_d [LANES];

    logic [LANES-1:0] full_c;
    logic [LANES-1:0] push_c;
    logic [LANES-1:0] drop_c;
    logic [LANES-1:0] pop_c;

    logic [LW-1:0]    rr_q;
    logic [LW-1:0]    rr_d;
    logic [W-1:0]     data_q;
    logic [W-1:0]     data_d;
    logic             valid_q;
    logic             valid_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             load_ok_c;
    logic             head_avail_c;

    // Output stage and read-lane pointer: only the lane at rr_q may be consumed.
    always_comb begin
        load_ok_c    = !valid_q || out_ready;
        head_avail_c = (cnt_q[rr_q] != '0);
        data_d       = data_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        pop_c        = '0;
        if (load_ok_c && head_avail_c) begin
            data_d      = mem_q[rr_q][rd_q[rr_q]];
            valid_d     = 1'b1;
            pop_c[rr_q] = 1'b1;
            rr_d        = rr_q + LW'(1);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Lane FIFO bookkeeping; a pop in the same cycle makes room for a write into a full FIFO.
    always_comb begin
        full_c = '0;
        push_c = '0;
        drop_c = '0;
        for (int i = 0; i < LANES; i++) begin
            full_c[i] = (cnt_q[i] == CW'(DEPTH));
            push_c[i] = lane_valid[i] && (!full_c[i] || pop_c[i]);
            drop_c[i] = lane_valid[i] && full_c[i] && !pop_c[i];
            wr_d[i]   = push_c[i] ? wr_q[i] + AW'(1) : wr_q[i];
            rd_d[i]   = pop_c[i] ? rd_q[i] + AW'(1) : rd_q[i];
            cnt_d[i]  = cnt_q[i] + CW'(push_c[i]) - CW'(pop_c[i]);
        end
        ovf_d = ovf_q || (|drop_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_c[i]) begin
                mem_q[i][wr_q[i]] <= lane_data[W*i +: W];
            end
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_full = full_c;
    assign overflow  = ovf_q;

endmodule
